// File: rtl/bus_cmd_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_cmd_buffer_pkg
//  Description : Shared OCP command/response encodings and width helpers for
//                the bus command buffer slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_cmd_buffer_pkg;

    // OCP MCmd encoding (3 bits on the wire)
    typedef enum logic [2:0] {
        CMD_IDLE = 3'd0,
        CMD_WR   = 3'd1,
        CMD_RD   = 3'd2
    } ocp_cmd_e;

    // OCP SResp encoding (2 bits on the wire)
    typedef enum logic [1:0] {
        RESP_NULL = 2'd0,
        RESP_DVA  = 2'd1,
        RESP_FAIL = 2'd2,
        RESP_ERR  = 2'd3
    } ocp_resp_e;

    localparam int c_cmd_bits = 3;

    // Ceiling log2, usable in constant expressions for pointer/level widths
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Packed width of one command word (MCmd, MAddr, MData, MByteEn)
    function automatic int cmd_word_bits(input int addr_w, input int data_w);
        return c_cmd_bits + addr_w + data_w + data_w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_cmd_buffer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_fifo
//  Description : DEPTH-entry command storage with wrapping pointers and a
//                level counter from which full/empty are derived.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo
    import bus_cmd_buffer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic                      full,
    output logic                      empty,
    output logic [clog2(DEPTH):0]     level
);

    localparam int c_ptr_w = clog2(DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_lvl_w-1:0] c_lvl_one  = c_lvl_w'(1);
    localparam logic [c_lvl_w-1:0] c_lvl_full = c_lvl_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic               w_do_push;
    logic               w_do_pop;

    // Guard against over/underflow even if the caller misbehaves
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Entry storage: contents need no reset, empty masking hides stale data
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers and fill level; pointers wrap naturally at DEPTH (power of 2)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_level == c_lvl_full);
    assign empty = (r_level == '0);
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/bus_cmd_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_cmd_buffer
//  Description : Elastic OCP command buffer in front of the serial bus bridge.
//                Queues commands, throttles response-bearing commands to
//                MAX_OUTSTANDING in flight and passes responses straight
//                through while tracking them.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_cmd_buffer
    import bus_cmd_buffer_pkg::*;
#(
    parameter int   ADDR_WIDTH      = 32,
    parameter int   DATA_WIDTH      = 32,
    parameter int   DEPTH           = 4,
    parameter int   MAX_OUTSTANDING = 4,
    parameter logic WRITE_RESP      = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    // upstream master side
    input  ocp_cmd_e                  up_mcmd,
    input  logic [ADDR_WIDTH-1:0]     up_maddr,
    input  logic [DATA_WIDTH-1:0]     up_mdata,
    input  logic [DATA_WIDTH/8-1:0]   up_mbyteen,
    output logic                      up_scmdaccept,
    output ocp_resp_e                 up_sresp,
    output logic [DATA_WIDTH-1:0]     up_sdata,
    input  logic                      up_mrespaccept,
    // downstream bridge side
    output ocp_cmd_e                  dn_mcmd,
    output logic [ADDR_WIDTH-1:0]     dn_maddr,
    output logic [DATA_WIDTH-1:0]     dn_mdata,
    output logic [DATA_WIDTH/8-1:0]   dn_mbyteen,
    input  logic                      dn_scmdaccept,
    input  ocp_resp_e                 dn_sresp,
    input  logic [DATA_WIDTH-1:0]     dn_sdata,
    output logic                      dn_mrespaccept,
    // status
    output logic [clog2(DEPTH):0]     level,
    output logic                      resp_err
);

    localparam int c_word_w = cmd_word_bits(ADDR_WIDTH, DATA_WIDTH);
    localparam logic [3:0] c_max_out = 4'(MAX_OUTSTANDING);
    localparam logic [3:0] c_out_one = 4'd1;

    typedef struct packed {
        ocp_cmd_e                mcmd;
        logic [ADDR_WIDTH-1:0]   maddr;
        logic [DATA_WIDTH-1:0]   mdata;
        logic [DATA_WIDTH/8-1:0] mbyteen;
    } cmd_word_t;

    cmd_word_t           w_in_word;
    cmd_word_t           w_head;
    logic [c_word_w-1:0] w_rd_word;
    logic                w_full;
    logic                w_empty;
    logic                w_counted;
    logic                w_push;
    logic                w_pop;
    logic                w_inc;
    logic                w_resp_hs;
    logic [3:0]          r_outstanding;
    logic                r_resp_err;

    // Reads always expect a response; writes only when WRITE_RESP is set
    assign w_counted = (up_mcmd == CMD_RD) || ((up_mcmd == CMD_WR) && WRITE_RESP);

    // Acceptance uses only registered state and up_mcmd, never dn_scmdaccept,
    // so a full buffer refuses even when the head drains this cycle.
    // Held low while reset is asserted since the state is already cleared.
    assign w_push = !reset && (up_mcmd != CMD_IDLE) && !w_full &&
                    !(w_counted && (r_outstanding == c_max_out));
    assign w_pop     = !w_empty && dn_scmdaccept;
    assign w_inc     = w_push && w_counted;
    assign w_resp_hs = (dn_sresp != RESP_NULL) && up_mrespaccept;

    assign w_in_word.mcmd    = up_mcmd;
    assign w_in_word.maddr   = up_maddr;
    assign w_in_word.mdata   = up_mdata;
    assign w_in_word.mbyteen = up_mbyteen;

    cmd_fifo #(
        .WIDTH (c_word_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_in_word),
        .rdata (w_rd_word),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    // Outstanding response tracker; a response with nothing in flight is
    // flagged stickily instead of wrapping the counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            case ({w_inc, w_resp_hs})
                2'b10: r_outstanding <= r_outstanding + c_out_one;
                2'b01: begin
                    if (r_outstanding == '0) begin
                        r_resp_err <= 1'b1;
                    end else begin
                        r_outstanding <= r_outstanding - c_out_one;
                    end
                end
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Head presentation: zeroed/IDLE when nothing is queued
    always_comb begin
        w_head = cmd_word_t'(w_rd_word);
        if (w_empty) begin
            dn_mcmd    = CMD_IDLE;
            dn_maddr   = '0;
            dn_mdata   = '0;
            dn_mbyteen = '0;
        end else begin
            dn_mcmd    = w_head.mcmd;
            dn_maddr   = w_head.maddr;
            dn_mdata   = w_head.mdata;
            dn_mbyteen = w_head.mbyteen;
        end
    end

    assign up_scmdaccept  = w_push;
    assign up_sresp       = dn_sresp;
    assign up_sdata       = dn_sdata;
    assign dn_mrespaccept = up_mrespaccept;
    assign resp_err       = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_cmd_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_cmd_buffer
//  Description : Self-checking bench for bus_cmd_buffer against a queue-based
//                reference model; directed scenarios then random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_cmd_buffer;
    import bus_cmd_buffer_pkg::*;

    localparam int   P_AW    = 32;
    localparam int   P_DW    = 32;
    localparam int   P_DEPTH = 4;
    localparam int   P_MAX   = 2;
    localparam logic P_WRESP = 1'b0;

    logic              clk;
    logic              reset;
    ocp_cmd_e          up_mcmd;
    logic [P_AW-1:0]   up_maddr;
    logic [P_DW-1:0]   up_mdata;
    logic [P_DW/8-1:0] up_mbyteen;
    logic              up_scmdaccept;
    ocp_resp_e         up_sresp;
    logic [P_DW-1:0]   up_sdata;
    logic              up_mrespaccept;
    ocp_cmd_e          dn_mcmd;
    logic [P_AW-1:0]   dn_maddr;
    logic [P_DW-1:0]   dn_mdata;
    logic [P_DW/8-1:0] dn_mbyteen;
    logic              dn_scmdaccept;
    ocp_resp_e         dn_sresp;
    logic [P_DW-1:0]   dn_sdata;
    logic              dn_mrespaccept;
    logic [2:0]        level;
    logic              resp_err;

    bus_cmd_buffer #(
        .ADDR_WIDTH      (P_AW),
        .DATA_WIDTH      (P_DW),
        .DEPTH           (P_DEPTH),
        .MAX_OUTSTANDING (P_MAX),
        .WRITE_RESP      (P_WRESP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .up_mcmd        (up_mcmd),
        .up_maddr       (up_maddr),
        .up_mdata       (up_mdata),
        .up_mbyteen     (up_mbyteen),
        .up_scmdaccept  (up_scmdaccept),
        .up_sresp       (up_sresp),
        .up_sdata       (up_sdata),
        .up_mrespaccept (up_mrespaccept),
        .dn_mcmd        (dn_mcmd),
        .dn_maddr       (dn_maddr),
        .dn_mdata       (dn_mdata),
        .dn_mbyteen     (dn_mbyteen),
        .dn_scmdaccept  (dn_scmdaccept),
        .dn_sresp       (dn_sresp),
        .dn_sdata       (dn_sdata),
        .dn_mrespaccept (dn_mrespaccept),
        .level          (level),
        .resp_err       (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an in-order queue plus an in-flight count
    typedef struct {
        ocp_cmd_e          cmd;
        logic [P_AW-1:0]   addr;
        logic [P_DW-1:0]   data;
        logic [P_DW/8-1:0] be;
    } ent_t;

    ent_t q[$];
    int   m_outst;
    logic m_err;
    int   n_checks;
    int   n_errors;
    logic last_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_outst = 0;
        m_err   = 1'b0;
    endtask

    // One clock cycle: drive at negedge, compare all outputs, advance model at posedge
    task automatic step(input ocp_cmd_e cmd, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic dacc, input ocp_resp_e sr,
                        input logic [31:0] sd, input logic racc);
        logic exp_acc;
        logic counted;
        logic pop;
        ent_t e;
        ent_t h;
        @(negedge clk);
        up_mcmd        = cmd;
        up_maddr       = a;
        up_mdata       = d;
        up_mbyteen     = be;
        dn_scmdaccept  = dacc;
        dn_sresp       = sr;
        dn_sdata       = sd;
        up_mrespaccept = racc;
        #1;
        counted = (cmd == CMD_RD) || ((cmd == CMD_WR) && P_WRESP);
        exp_acc = (cmd != CMD_IDLE) && (q.size() < P_DEPTH) && !(counted && (m_outst == P_MAX));
        if (q.size() > 0) h = q[0];
        else begin
            h.cmd = CMD_IDLE; h.addr = '0; h.data = '0; h.be = '0;
        end
        check("accept",   up_scmdaccept, exp_acc);
        check("dn_mcmd",  dn_mcmd, h.cmd);
        check("dn_maddr", dn_maddr, h.addr);
        check("dn_mdata", dn_mdata, h.data);
        check("dn_be",    dn_mbyteen, h.be);
        check("level",    level, q.size());
        check("resp_err", resp_err, m_err);
        check("sresp",    up_sresp, sr);
        check("sdata",    up_sdata, sd);
        check("raccept",  dn_mrespaccept, racc);
        last_acc = up_scmdaccept;
        pop = (q.size() > 0) && dacc;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (exp_acc) begin
            e.cmd = cmd; e.addr = a; e.data = d; e.be = be;
            q.push_back(e);
        end
        if ((exp_acc && counted) && !(sr != RESP_NULL && racc)) m_outst++;
        else if (!(exp_acc && counted) && (sr != RESP_NULL && racc)) begin
            if (m_outst == 0) m_err = 1'b1;
            else m_outst--;
        end
    endtask

    task automatic idle(input logic dacc);
        step(CMD_IDLE, 32'h0, 32'h0, 4'h0, dacc, RESP_NULL, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        up_mcmd = CMD_WR;
        #1;
        check("rst_accept", up_scmdaccept, 1'b0);
        check("rst_dn_mcmd", dn_mcmd, CMD_IDLE);
        check("rst_dn_maddr", dn_maddr, 32'h0);
        check("rst_level", level, 3'd0);
        check("rst_resp_err", resp_err, 1'b0);
        model_clear();
        up_mcmd = CMD_IDLE;
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_clear();
        reset = 1'b1;
        up_mcmd = CMD_IDLE; up_maddr = '0; up_mdata = '0; up_mbyteen = '0;
        dn_scmdaccept = 1'b0; dn_sresp = RESP_NULL; dn_sdata = '0; up_mrespaccept = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;

        // Single transfer, 1-cycle latency, then empty again
        step(CMD_RD, 32'h10, 32'h0, 4'hf, 1'b1, RESP_NULL, 32'h0, 1'b0);
        #1 check("single_dn_cmd", dn_mcmd, CMD_RD);
        check("single_dn_addr", dn_maddr, 32'h10);
        idle(1'b1);
        #1 check("single_idle", dn_mcmd, CMD_IDLE);
        step(CMD_IDLE, 32'h0, 32'h0, 4'h0, 1'b0, RESP_DVA, 32'hCAFE, 1'b1);

        // Fill: six writes with the bridge stalled, four land
        for (int i = 0; i < 6; i++)
            step(CMD_WR, 32'h100 + i, i, 4'hf, 1'b0, RESP_NULL, 32'h0, 1'b0);
        #1 check("fill_level", level, 3'd4);
        check("fill_refused", last_acc, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Full with simultaneous pop: refused, then accepted
        for (int i = 0; i < 4; i++)
            step(CMD_WR, 32'h200 + i, 32'hA0 + i, 4'h3, 1'b0, RESP_NULL, 32'h0, 1'b0);
        step(CMD_WR, 32'h2FF, 32'hFF, 4'h1, 1'b1, RESP_NULL, 32'h0, 1'b0);
        check("full_pop_refused", last_acc, 1'b0);
        #1 check("full_pop_level", level, 3'd3);
        step(CMD_WR, 32'h2FF, 32'hFF, 4'h1, 1'b0, RESP_NULL, 32'h0, 1'b0);
        check("full_pop_retry", last_acc, 1'b1);
        #1 check("full_pop_level2", level, 3'd4);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Throttle at two reads in flight
        for (int i = 0; i < 3; i++)
            step(CMD_RD, 32'h300 + i, 32'h0, 4'hf, 1'b1, RESP_NULL, 32'h0, 1'b0);
        check("thr_hold", last_acc, 1'b0);
        step(CMD_RD, 32'h302, 32'h0, 4'hf, 1'b1, RESP_DVA, 32'h55, 1'b1);
        step(CMD_RD, 32'h302, 32'h0, 4'hf, 1'b1, RESP_NULL, 32'h0, 1'b0);
        check("thr_release", last_acc, 1'b1);

        // Spurious response with nothing in flight
        do_reset();
        step(CMD_IDLE, 32'h0, 32'h0, 4'h0, 1'b0, RESP_DVA, 32'h77, 1'b1);
        #1 check("spur_err", resp_err, 1'b1);
        for (int i = 0; i < 3; i++)
            step(CMD_RD, 32'h400 + i, 32'h0, 4'hf, 1'b1, RESP_NULL, 32'h0, 1'b0);
        check("spur_cnt_zero", last_acc, 1'b0);

        // Reset mid-stream with queued and in-flight commands
        do_reset();
        step(CMD_RD, 32'h500, 32'h0, 4'hf, 1'b0, RESP_NULL, 32'h0, 1'b0);
        step(CMD_RD, 32'h504, 32'h0, 4'hf, 1'b0, RESP_NULL, 32'h0, 1'b0);
        step(CMD_WR, 32'h508, 32'h9, 4'hf, 1'b0, RESP_NULL, 32'h0, 1'b0);
        do_reset();
        step(CMD_RD, 32'h600, 32'h0, 4'hf, 1'b0, RESP_NULL, 32'h0, 1'b0);
        check("post_rst_accept", last_acc, 1'b1);
        #1 check("post_rst_head", dn_maddr, 32'h600);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ocp_cmd_e  c;
            ocp_resp_e r;
            c = ocp_cmd_e'(3'($urandom_range(0, 2)));
            r = ($urandom_range(0, 3) == 0) ? ocp_resp_e'(2'($urandom_range(1, 3))) : RESP_NULL;
            step(c, $urandom, $urandom, 4'($urandom), 1'($urandom), r, $urandom, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
